// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types, sizes, LUT contents and expansion helper for the immediate sequencer
package imm_pkg;

    localparam int WIDTH      = 8;
    localparam int CHUNK      = 2;
    localparam int MAX_CHUNKS = WIDTH / CHUNK;
    localparam int LUT_DEPTH  = 16;
    localparam int LUT_IDX_W  = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {
        IMM_LUT  = 2'b00,
        IMM_SEXT = 2'b01,
        IMM_UNS  = 2'b10,
        IMM_RSVD = 2'b11
    } immMode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } immState_t;

    // Constant table selected by the low accumulator bits in LUT mode
    function automatic logic [WIDTH-1:0] lutEntry(input logic [LUT_IDX_W-1:0] idx);
        logic [WIDTH-1:0] data;
        case (idx)
            4'h0: data = 8'h00;
            4'h1: data = 8'h01;
            4'h2: data = 8'h02;
            4'h3: data = 8'h04;
            4'h4: data = 8'h08;
            4'h5: data = 8'h10;
            4'h6: data = 8'h20;
            4'h7: data = 8'h40;
            4'h8: data = 8'h80;
            4'h9: data = 8'hFF;
            4'hA: data = 8'h7F;
            4'hB: data = 8'hF0;
            4'hC: data = 8'h0F;
            4'hD: data = 8'hAA;
            4'hE: data = 8'h55;
            default: data = 8'hC3;
        endcase
        return data;
    endfunction

    // Replicate the top received bit across the unfilled upper bits; acc is right-aligned
    function automatic logic [WIDTH-1:0] signExtend(input logic [WIDTH-1:0] acc, input logic [2:0] cnt);
        logic [WIDTH-1:0] ext;
        case (cnt)
            3'd1:    ext = {{6{acc[1]}}, acc[1:0]};
            3'd2:    ext = {{4{acc[3]}}, acc[3:0]};
            3'd3:    ext = {{2{acc[5]}}, acc[5:0]};
            default: ext = acc;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/imm_lut.sv
// rtl/imm_lut.sv - combinational 16x8 immediate ROM
module imm_lut
    import imm_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] index,
    output logic [WIDTH-1:0]     data
);

    assign data = lutEntry(index);

endmodule

// File: rtl/imm_build_seq.sv
// rtl/imm_build_seq.sv - multi-cycle immediate assembler with expansion and valid/ready output
module imm_build_seq
    import imm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             chunk_valid,
    input  logic [CHUNK-1:0] chunk,
    input  logic             chunk_last,
    output logic             chunk_ready,
    output logic             imm_valid,
    output logic [WIDTH-1:0] imm_value,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    localparam logic [2:0] CNT_MAX = 3'(MAX_CHUNKS);

    immState_t        state, stateNext;
    logic [WIDTH-1:0] acc, accNext;
    logic [2:0]       cnt, cntNext;
    immMode_t         modeQ, modeNext;
    logic             errQ, errNext;
    logic [WIDTH-1:0] immQ, immNext;

    logic [WIDTH-1:0] shifted;
    logic [2:0]       cntInc;
    logic [WIDTH-1:0] lutData;
    logic [WIDTH-1:0] expanded;

    // Accumulator after taking the current chunk; count saturates rather than wrapping
    assign shifted = (acc << CHUNK) | {{(WIDTH-CHUNK){1'b0}}, chunk};
    assign cntInc  = (cnt >= CNT_MAX) ? cnt : cnt + 3'd1;

    imm_lut uLut (
        .index (shifted[LUT_IDX_W-1:0]),
        .data  (lutData)
    );

    // Expansion of the would-be accumulator so the result registers on the completing edge
    always_comb begin
        expanded = shifted;
        case (modeQ)
            IMM_LUT:  expanded = lutData;
            IMM_SEXT: expanded = signExtend(shifted, cntInc);
            default:  expanded = shifted;
        endcase
    end

    // Next-state and datapath updates; start always re-arms and clears stale error
    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        modeNext  = modeQ;
        errNext   = errQ;
        immNext   = immQ;
        case (state)
            S_IDLE: begin
                if (start) begin
                    stateNext = S_ACCUM;
                    accNext   = '0;
                    cntNext   = '0;
                    modeNext  = immMode_t'(mode);
                    errNext   = (mode == 2'b11);
                end
            end
            S_ACCUM: begin
                if (start) begin
                    accNext  = '0;
                    cntNext  = '0;
                    modeNext = immMode_t'(mode);
                    errNext  = (mode == 2'b11);
                end else if (chunk_valid) begin
                    accNext = shifted;
                    cntNext = cntInc;
                    if (chunk_last || cntInc == CNT_MAX) begin
                        stateNext = S_DONE;
                        immNext   = expanded;
                    end
                end
            end
            S_DONE: begin
                if (chunk_valid) begin
                    errNext = 1'b1;
                end
                if (out_ready) begin
                    if (start) begin
                        stateNext = S_ACCUM;
                        accNext   = '0;
                        cntNext   = '0;
                        modeNext  = immMode_t'(mode);
                        errNext   = (mode == 2'b11);
                    end else begin
                        stateNext = S_IDLE;
                    end
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath registers: accumulator, count, latched mode, sticky error, result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            modeQ <= IMM_LUT;
            errQ  <= 1'b0;
            immQ  <= '0;
        end else begin
            acc   <= accNext;
            cnt   <= cntNext;
            modeQ <= modeNext;
            errQ  <= errNext;
            immQ  <= immNext;
        end
    end

    assign chunk_ready = (state == S_ACCUM);
    assign imm_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign imm_value   = immQ;
    assign err         = errQ;

endmodule

// File: tb/tb_imm_build_seq.sv
// tb/tb_imm_build_seq.sv - scoreboard bench with directed and randomized immediates
module tb_imm_build_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic       chunk_valid;
    logic [1:0] chunk;
    logic       chunk_last;
    logic       chunk_ready;
    logic       imm_valid;
    logic [7:0] imm_value;
    logic       out_ready;
    logic       busy;
    logic       err;

    int checkCount = 0;
    int passCount  = 0;
    logic [7:0] expQ[$];

    imm_build_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .chunk_valid (chunk_valid),
        .chunk       (chunk),
        .chunk_last  (chunk_last),
        .chunk_ready (chunk_ready),
        .imm_valid   (imm_valid),
        .imm_value   (imm_value),
        .out_ready   (out_ready),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: value of the received bits read as a 2n-bit number, then expanded
    function automatic logic [7:0] refImm(input int m, input int n, input int v);
        int bits;
        bits = 2 * n;
        case (m)
            0: return imm_pkg::lutEntry(4'(v & 15));
            1: begin
                if (v >= (1 << (bits - 1))) return 8'((v - (1 << bits)) & 255);
                else return 8'(v);
            end
            default: return 8'(v);
        endcase
    endfunction

    // Monitor: pop and compare on each accepted result; check holding stability otherwise
    logic       prevValid = 1'b0;
    logic       prevReady = 1'b0;
    logic [7:0] prevValue = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (prevValid && !prevReady && imm_valid)
                check("hold_stable", imm_value, prevValue);
            if (imm_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("imm_value", imm_value, expQ.pop_front());
                end
            end
            prevValid = imm_valid;
            prevReady = out_ready;
            prevValue = imm_value;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendChunks(input int m, input int n, input int v, input bit useLast);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                chunk_valid = 1'b0;
                tick();
            end
            chunk_valid = 1'b1;
            chunk       = 2'((v >> (2 * (n - 1 - i))) & 3);
            chunk_last  = useLast && (i == n - 1);
            tick();
        end
        chunk_valid = 1'b0;
        chunk_last  = 1'b0;
        expQ.push_back(refImm(m, n, v));
        check("latency_valid", imm_valid, 1);
    endtask

    task automatic sendImm(input int m, input int n, input int v, input bit useLast);
        start = 1'b1;
        mode  = 2'(m);
        tick();
        start = 1'b0;
        sendChunks(m, n, v, useLast);
    endtask

    task automatic drain(input int hold);
        out_ready = 1'b0;
        repeat (hold) tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!busy) break;
            tick();
        end
        check("drain_idle", busy, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'b00; chunk_valid = 1'b0;
        chunk = 2'b00; chunk_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_valid", imm_valid, 0);
        check("rst_value", imm_value, 0);
        check("rst_ready", chunk_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Unsigned, four chunks forcing completion
        sendImm(2, 4, 8'hD8, 1'b0);
        check("t1_ready_low", chunk_ready, 0);
        drain(0);

        // Sign-extend short immediates
        sendImm(1, 2, 4'b1011, 1'b1);
        drain(1);
        sendImm(1, 2, 4'b0111, 1'b1);
        drain(0);

        // LUT with a long hold and an overflow chunk during the hold
        sendImm(0, 2, 4'b0011, 1'b1);
        check("t3_err_before", err, 0);
        repeat (5) begin
            tick();
            check("t3_hold_valid", imm_valid, 1);
        end
        chunk_valid = 1'b1;
        chunk       = 2'b10;
        tick();
        chunk_valid = 1'b0;
        check("t3_err_overflow", err, 1);
        check("t3_value_kept", imm_value, imm_pkg::lutEntry(4'h3));
        drain(1);

        // Restart discards the partial immediate and re-evaluates error
        start = 1'b1; mode = 2'b11; tick(); start = 1'b0;
        check("t4_err_rsvd", err, 1);
        chunk_valid = 1'b1; chunk = 2'b11; tick(); chunk_valid = 1'b0;
        start = 1'b1; mode = 2'b01; tick(); start = 1'b0;
        check("t4_err_cleared", err, 0);
        check("t4_busy", busy, 1);
        sendChunks(1, 1, 1, 1'b1);
        drain(0);

        // Back-to-back: handshake and new start on the same edge
        sendImm(2, 2, 4'b1010, 1'b1);
        out_ready = 1'b1; start = 1'b1; mode = 2'b10;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("t5_busy", busy, 1);
        check("t5_ready", chunk_ready, 1);
        check("t5_valid", imm_valid, 0);
        sendChunks(2, 2, 4'b1001, 1'b1);
        drain(0);

        // Reset mid-accumulation, then reserved mode behaves as unsigned with err
        start = 1'b1; mode = 2'b10; tick(); start = 1'b0;
        chunk_valid = 1'b1; chunk = 2'b01; tick(); chunk = 2'b10; tick();
        chunk_valid = 1'b0;
        rst_n = 1'b0; tick();
        check("t6_valid", imm_valid, 0);
        check("t6_value", imm_value, 0);
        check("t6_ready", chunk_ready, 0);
        check("t6_busy", busy, 0);
        check("t6_err", err, 0);
        rst_n = 1'b1; tick();
        sendImm(3, 3, 6'b101101, 1'b1);
        check("t6_err_rsvd", err, 1);
        drain(0);

        // Randomized immediates
        for (int t = 0; t < 40; t++) begin
            int m, n, v;
            bit useLast;
            m = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            v = $urandom_range(0, (1 << (2 * n)) - 1);
            useLast = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            sendImm(m, n, v, useLast);
            check("rand_err", err, (m == 3) ? 1 : 0);
            drain($urandom_range(0, 3));
        end

        tick();
        check("queue_empty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
